seg_scan_display: RTL and testbench
===================================

// Module: seg_scan_display
// PURPOSE
//   Parametrised multiplexed 7-segment driver for the water-level panel. It replaces the fixed
//   4-digit scanner. Takes a binary level value and converts it to BCD sequentially (shift-add-3,
//   one bit per clock), holds the result in a double-buffered digit store, and scans NUM_DIGITS
//   cathodes at a programmable rate.
//   Adds decimal-point placement, leading-zero blanking, overflow indication and an auxiliary
//   digit (pump speed) on the leftmost position.
// PARAMETERS
//   NUM_DIGITS  8     cathodes driven; cat[0] = rightmost digit
//   BCD_DIGITS  4     digits used for value (1..NUM_DIGITS-1), positions 0..BCD_DIGITS-1
//   VALUE_W     14    width of binary input value
//   SCAN_DIV    1000  clk cycles each digit stays lit (>=2)
// PORTS
//   clk         in   1           system clock
//   rst         in   1           synchronous, active-high reset
//   value_in    in   VALUE_W     unsigned value in display units (e.g. 105 = 10.5 m with dp_pos=1)
//   value_load  in   1           1-cycle strobe: start conversion of value_in
//   busy        out  1           conversion in progress; loads ignored while high
//   overflow    out  1           last converted value >= 10**BCD_DIGITS
//   dp_en       in   1           enable decimal point
//   dp_pos      in   3           digit index carrying the dot (valid 0..BCD_DIGITS-1)
//   blank_lz    in   1           1 = blank leading zeros
//   aux_en      in   1           show aux_digit on digit NUM_DIGITS-1
//   aux_digit   in   4           auxiliary value (pump speed 0..9)
//   seg         out  7           segments, seg[6]=a .. seg[0]=g, active-high
//   seg_dot     out  1           decimal point, active-high
//   cat         out  NUM_DIGITS  digit enables, active-low, one-hot-low while scanning
// BEHAVIOUR
//   Reset (rst=1 at a clk edge):
//     - busy=0, overflow=0, prescaler=0, scan index=0, all digit buffers=0.
//     - cat=all 1s, seg=0, seg_dot=0.
//     - An in-flight conversion is aborted; the buffer stays 0.
//   Converter FSM: IDLE -> SHIFT -> COMMIT -> IDLE.
//     - IDLE: value_load=1 captures value_in and zeros the BCD accumulator (BCD_DIGITS*4 plus 4
//       guard bits). Enters SHIFT; busy=1 from the next cycle.
//     - SHIFT: VALUE_W cycles. Each cycle, every BCD nibble >=5 gets +3, then {bcd,bin} shifts
//       left by 1.
//     - COMMIT: 1 cycle. Buffer <= low BCD_DIGITS nibbles; overflow <= (guard nibble !=0) or
//       (value >= 10**BCD_DIGITS). Returns to IDLE with busy=0.
//     - Load-to-busy-fall latency is VALUE_W+2 cycles. New digits are displayed from the cycle
//       after COMMIT.
//     - value_load while busy is ignored (no queueing). A load in the same cycle as COMMIT is
//       also ignored.
//     - The buffer changes atomically; the display never shows a partially converted value.
//   Scan:
//     - The prescaler counts 0..SCAN_DIV-1.
//     - At terminal count the index advances; it wraps from NUM_DIGITS-1 to 0.
//     - cat, seg and seg_dot are registered from the current index and update 1 cycle after the
//       index changes.
//   Digit content for index i:
//     - i < BCD_DIGITS:
//       - overflow=1 shows dash (seg=7'b0000001), no dot.
//       - Otherwise shows nibble i.
//       - The nibble is blanked (seg=0) when blank_lz=1, i > (dp_en?dp_pos:0), and all nibbles
//         from i up to BCD_DIGITS-1 are 0.
//     - i = NUM_DIGITS-1 with aux_en=1: aux_digit; values >9 shown blank.
//     - All other indices: seg=0. Their cat bit still goes low (keeps duty uniform).
//     - seg_dot=1 only when dp_en=1 and i==dp_pos and overflow=0. dp_pos >= BCD_DIGITS gives no
//       dot.
//   Decode (abcdefg):
//     - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
//     - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
//   dp_pos, dp_en, blank_lz and aux_* are sampled live each cycle and are not latched by
//   value_load.
// TESTING (NUM_DIGITS=8, BCD_DIGITS=4, VALUE_W=14, SCAN_DIV=4)
//   1 Reset held 3 cycles, released -> cat=8'hFF, busy=0. From the next cycle cat=8'hFE,
//     then 8'hFD after 4 cycles; wraps to 8'hFE after 32 cycles.
//   2 load 105, dp_en=1, dp_pos=1, blank_lz=1 -> busy high 15 cycles. Digits 0/1/2 =
//     1011011 / 1111110 / 0110000, dot only on digit 1, digit 3 seg=0.
//   3 load 5, dp_pos=1, blank_lz=1 -> digit1=0 with dot (shows "0.5"), digits 2-3 blank.
//     Same value with blank_lz=0 -> digits 2-3 show 1111110.
//   4 load 12345 -> overflow=1, digits 0-3 seg=0000001, no dot.
//     Then load 9999 -> overflow=0, all four show 1111011.
//   5 load 42, then load 77 two cycles later (busy) -> the second load is ignored and 42 is
//     shown. Then rst mid-conversion -> busy=0, digits 0.
//   6 aux_en=1, aux_digit=2 -> at index 7 cat=8'h7F, seg=1101101.
//     aux_digit=12 -> seg=0. aux_en=0 -> seg=0.

Source files
------------

// File: rtl/seg_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_display
// Description : Multiplexed 7-segment driver. It converts a binary value to BCD
//               one bit per clock and scans NUM_DIGITS cathodes.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_display #(
  parameter int NUM_DIGITS = 8,
  parameter int BCD_DIGITS = 4,
  parameter int VALUE_W    = 14,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VALUE_W-1:0]    value_in,
  input  logic                  value_load,
  output logic                  busy,
  output logic                  overflow,
  input  logic                  dp_en,
  input  logic [2:0]            dp_pos,
  input  logic                  blank_lz,
  input  logic                  aux_en,
  input  logic [3:0]            aux_digit,
  output logic [6:0]            seg,
  output logic                  seg_dot,
  output logic [NUM_DIGITS-1:0] cat
);

  localparam int c_BCD_W = BCD_DIGITS*4 + 4;
  localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_PRE_W = $clog2(SCAN_DIV);
  localparam int c_CNT_W = $clog2(VALUE_W + 1);
  localparam logic [31:0] c_LIMIT = 32'(10**BCD_DIGITS);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_SHIFT  = 2'd1;
  localparam logic [1:0] c_COMMIT = 2'd2;

  logic [1:0]              r_state;
  logic [VALUE_W-1:0]      r_bin;
  logic [VALUE_W-1:0]      r_value;
  logic [c_BCD_W-1:0]      r_bcd;
  logic [c_CNT_W-1:0]      r_cnt;
  logic [BCD_DIGITS*4-1:0] r_digits;
  logic                    r_overflow;
  logic [c_PRE_W-1:0]      r_presc;
  logic [c_IDX_W-1:0]      r_idx;
  logic [NUM_DIGITS-1:0]   r_cat;
  logic [6:0]              r_seg;
  logic                    r_dot;

  logic [c_BCD_W-1:0]      w_bcd_adj;
  logic [3:0]              w_nib;
  logic                    w_upper_zero;
  int                      w_lz_limit;
  logic [6:0]              w_seg;
  logic                    w_dot;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'd0:    f_decode = 7'b1111110;
      4'd1:    f_decode = 7'b0110000;
      4'd2:    f_decode = 7'b1101101;
      4'd3:    f_decode = 7'b1111001;
      4'd4:    f_decode = 7'b0110011;
      4'd5:    f_decode = 7'b1011011;
      4'd6:    f_decode = 7'b1011111;
      4'd7:    f_decode = 7'b1110000;
      4'd8:    f_decode = 7'b1111111;
      4'd9:    f_decode = 7'b1111011;
      default: f_decode = 7'b0000000;
    endcase
  endfunction

  // Add-3 correction on every nibble, including the guard nibble.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int n = 0; n < BCD_DIGITS + 1; n++) begin
      if (r_bcd[n*4 +: 4] >= 4'd5)
        w_bcd_adj[n*4 +: 4] = r_bcd[n*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_IDLE;
      r_bin      <= '0;
      r_value    <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_digits   <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (value_load) begin
            r_bin   <= value_in;
            r_value <= value_in;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_state <= c_SHIFT;
          end
        end
        c_SHIFT: begin
          {r_bcd, r_bin} <= {w_bcd_adj[c_BCD_W-2:0], r_bin, 1'b0};
          r_cnt          <= r_cnt + 1'b1;
          if (r_cnt == c_CNT_W'(VALUE_W - 1))
            r_state <= c_COMMIT;
        end
        c_COMMIT: begin
          // Display store only changes here, so no partial value is ever shown.
          r_digits   <= r_bcd[BCD_DIGITS*4-1:0];
          r_overflow <= (r_bcd[c_BCD_W-1 -: 4] != 4'd0) || (32'(r_value) >= c_LIMIT);
          r_state    <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  always_comb begin
    w_nib        = 4'd0;
    w_upper_zero = 1'b1;
    w_lz_limit   = dp_en ? int'(dp_pos) : 0;
    w_seg        = 7'b0000000;
    w_dot        = 1'b0;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (k == int'(r_idx))
        w_nib = r_digits[k*4 +: 4];
      if (k >= int'(r_idx) && r_digits[k*4 +: 4] != 4'd0)
        w_upper_zero = 1'b0;
    end
    if (int'(r_idx) < BCD_DIGITS) begin
      if (r_overflow)
        w_seg = 7'b0000001;
      else if (blank_lz && int'(r_idx) > w_lz_limit && w_upper_zero)
        w_seg = 7'b0000000;
      else
        w_seg = f_decode(w_nib);
      w_dot = dp_en && !r_overflow && (int'(dp_pos) == int'(r_idx));
    end else if (int'(r_idx) == NUM_DIGITS - 1 && aux_en) begin
      w_seg = f_decode(aux_digit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_cat   <= '1;
      r_seg   <= 7'b0000000;
      r_dot   <= 1'b0;
    end else begin
      if (r_presc == c_PRE_W'(SCAN_DIV - 1)) begin
        r_presc <= '0;
        r_idx   <= (r_idx == c_IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      r_cat <= ~(NUM_DIGITS'(1) << r_idx);
      r_seg <= w_seg;
      r_dot <= w_dot;
    end
  end

  assign busy     = (r_state != c_IDLE);
  assign overflow = r_overflow;
  assign cat      = r_cat;
  assign seg      = r_seg;
  assign seg_dot  = r_dot;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_display
// Description : Directed self-checking bench for seg_scan_display (SCAN_DIV=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] value_in;
  logic        value_load;
  logic        busy;
  logic        overflow;
  logic        dp_en;
  logic [2:0]  dp_pos;
  logic        blank_lz;
  logic        aux_en;
  logic [3:0]  aux_digit;
  logic [6:0]  seg;
  logic        seg_dot;
  logic [7:0]  cat;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_scan_display #(
    .NUM_DIGITS(8), .BCD_DIGITS(4), .VALUE_W(14), .SCAN_DIV(4)
  ) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .value_load(value_load),
    .busy(busy), .overflow(overflow), .dp_en(dp_en), .dp_pos(dp_pos),
    .blank_lz(blank_lz), .aux_en(aux_en), .aux_digit(aux_digit),
    .seg(seg), .seg_dot(seg_dot), .cat(cat)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for digit i to be lit, then check its segments and dot.
  task automatic show(input string tag, input int i, input logic [6:0] es, input logic ed);
    logic [7:0] ec;
    int k;
    ec = ~(8'b1 << i);
    k  = 0;
    while (cat !== ec && k < 40) begin
      tick(1);
      k++;
    end
    chk({tag, "/cat"}, 32'(cat), 32'(ec));
    chk({tag, "/seg"}, 32'(seg), 32'(es));
    chk({tag, "/dot"}, 32'(seg_dot), 32'(ed));
  endtask

  task automatic load(input int v, input string tag);
    int k;
    value_in   = 14'(v);
    value_load = 1'b1;
    tick(1);
    value_load = 1'b0;
    k = 0;
    while (busy && k < 40) begin
      k++;
      tick(1);
    end
    chk({tag, "/busy_cycles"}, 32'(k), 32'd15);
  endtask

  initial begin
    int k;
    rst = 1'b1; value_in = '0; value_load = 1'b0; dp_en = 1'b0; dp_pos = 3'd0;
    blank_lz = 1'b0; aux_en = 1'b0; aux_digit = 4'd0;

    // Reset and scan timing
    tick(3);
    rst = 1'b0;
    chk("rst/cat", 32'(cat), 32'hFF);
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/ovf", 32'(overflow), 32'd0);
    chk("rst/seg", 32'(seg), 32'd0);
    chk("rst/dot", 32'(seg_dot), 32'd0);
    tick(1);
    chk("scan/e1", 32'(cat), 32'hFE);
    tick(3);
    chk("scan/e4", 32'(cat), 32'hFE);
    tick(1);
    chk("scan/e5", 32'(cat), 32'hFD);
    tick(27);
    chk("scan/e32", 32'(cat), 32'h7F);
    tick(1);
    chk("scan/e33", 32'(cat), 32'hFE);

    // 105 shown as 10.5
    dp_en = 1'b1; dp_pos = 3'd1; blank_lz = 1'b1;
    load(105, "v105");
    chk("v105/ovf", 32'(overflow), 32'd0);
    show("v105/d0", 0, 7'b1011011, 1'b0);
    show("v105/d1", 1, 7'b1111110, 1'b1);
    show("v105/d2", 2, 7'b0110000, 1'b0);
    show("v105/d3", 3, 7'b0000000, 1'b0);

    // 5 shown as 0.5, then without blanking
    load(5, "v5");
    show("v5/d0", 0, 7'b1011011, 1'b0);
    show("v5/d1", 1, 7'b1111110, 1'b1);
    show("v5/d2", 2, 7'b0000000, 1'b0);
    show("v5/d3", 3, 7'b0000000, 1'b0);
    blank_lz = 1'b0;
    show("v5nb/d2", 2, 7'b1111110, 1'b0);
    show("v5nb/d3", 3, 7'b1111110, 1'b0);

    // Overflow and the largest in-range value
    load(12345, "v12345");
    chk("v12345/ovf", 32'(overflow), 32'd1);
    show("v12345/d0", 0, 7'b0000001, 1'b0);
    show("v12345/d1", 1, 7'b0000001, 1'b0);
    show("v12345/d3", 3, 7'b0000001, 1'b0);
    load(9999, "v9999");
    chk("v9999/ovf", 32'(overflow), 32'd0);
    show("v9999/d0", 0, 7'b1111011, 1'b0);
    show("v9999/d1", 1, 7'b1111011, 1'b1);
    show("v9999/d2", 2, 7'b1111011, 1'b0);
    show("v9999/d3", 3, 7'b1111011, 1'b0);

    // Load while busy is ignored
    dp_en = 1'b0;
    value_in = 14'd42; value_load = 1'b1;
    tick(1);
    value_load = 1'b0;
    tick(1);
    value_in = 14'd77; value_load = 1'b1;
    tick(1);
    value_load = 1'b0;
    k = 0;
    while (busy && k < 40) begin
      k++;
      tick(1);
    end
    chk("v42/busy_fall", 32'(busy), 32'd0);
    tick(1);
    chk("v42/busy_after", 32'(busy), 32'd0);
    show("v42/d0", 0, 7'b1101101, 1'b0);
    show("v42/d1", 1, 7'b0110011, 1'b0);
    show("v42/d2", 2, 7'b1111110, 1'b0);

    // Reset mid-conversion
    value_in = 14'd100; value_load = 1'b1;
    tick(1);
    value_load = 1'b0;
    tick(5);
    chk("midrst/busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst/busy", 32'(busy), 32'd0);
    chk("midrst/cat", 32'(cat), 32'hFF);
    tick(20);
    chk("midrst/busy_late", 32'(busy), 32'd0);
    show("midrst/d0", 0, 7'b1111110, 1'b0);
    show("midrst/d2", 2, 7'b1111110, 1'b0);

    // Auxiliary digit and unused positions
    aux_en = 1'b1; aux_digit = 4'd2;
    show("aux2/d7", 7, 7'b1101101, 1'b0);
    show("aux2/d5", 5, 7'b0000000, 1'b0);
    aux_digit = 4'd12;
    show("aux12/d7", 7, 7'b0000000, 1'b0);
    aux_en = 1'b0; aux_digit = 4'd2;
    show("auxoff/d7", 7, 7'b0000000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
